seg_scan_ctrl: RTL and testbench

Time-multiplexed scan driver for the multi-digit 7-segment display path. Holds a small digit buffer written by the host logic and cycles a digit index at a fixed scan rate. Presents the index and the buffered nibble each cycle to the downstream segment/digit decoder: digit_sel drives its 3-bit select, digit_val its 4-bit value. Generates frame and tick strobes for the rest of the design.

---
 rtl/seg_scan_ctrl_if.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 94 +++++++++
 tb/tb_seg_scan_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Host/display bundle for seg_scan_ctrl: scan control and buffer writes in,
// registered select/value/strobes out.
interface seg_scan_ctrl_if;
  logic       hold;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [2:0] digit_sel;
  logic [3:0] digit_val;
  logic       digit_on;
  logic       scan_tick;
  logic       frame_done;

  modport master (
    output hold, wr_en, wr_addr, wr_data,
    input  digit_sel, digit_val, digit_on, scan_tick, frame_done
  );

  modport slave (
    input  hold, wr_en, wr_addr, wr_data,
    output digit_sel, digit_val, digit_on, scan_tick, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan driver with a small digit buffer.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits above index 0.
module seg_scan_ctrl #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIV      = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       val_q, val_d;
  logic             on_q, on_d;
  logic             tick_q, tick_d;
  logic             frame_q, frame_d;
  logic [3:0]       buf_q [N_DIGITS];
  logic [3:0]       buf_d [N_DIGITS];
  logic             adv;

  always_comb begin
    adv     = !bus.hold && (cnt_q == CNT_W'(DIV - 1));
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tick_d  = adv;
    frame_d = adv && (sel_q == 3'(N_DIGITS - 1));
    if (!bus.hold) begin
      cnt_d = adv ? '0 : cnt_q + CNT_W'(1);
    end
    if (adv) begin
      sel_d = (sel_q == 3'(N_DIGITS - 1)) ? 3'd0 : sel_q + 3'd1;
    end

    // Out-of-range addresses match no entry, so they are dropped here.
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      buf_d[i] = buf_q[i];
      if (bus.wr_en && (bus.wr_addr == 3'(i))) begin
        buf_d[i] = bus.wr_data;
      end
    end

    // Reading the post-write buffer gives the write bypass for free.
    val_d = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (sel_d == 3'(i)) begin
        val_d = buf_d[i];
      end
    end

`ifdef LEAD_ZERO_BLANK_EN
    on_d = (sel_d == 3'd0);
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if ((3'(i) >= sel_d) && (buf_d[i] != 4'd0)) begin
        on_d = 1'b1;
      end
    end
`else
    on_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      val_q   <= '0;
      on_q    <= 1'b0;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      on_q    <= on_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign bus.digit_sel  = sel_q;
  assign bus.digit_val  = val_q;
  assign bus.digit_on   = on_q;
  assign bus.scan_tick  = tick_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIGITS=4, DIV=4; expectations come
// from an edge counter and a shadow copy of the digit buffer.
module tb_seg_scan_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   e;
  logic [3:0] mb [4];

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .N_DIGITS(4),
    .DIV     (4),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // e counts non-held edges since reset release; it fully determines position.
  task automatic step();
    @(posedge clk);
    #1;
    if (!bus.hold) e++;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [3:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en = 1'b0;
    if (addr < 3'd4) mb[addr[1:0]] = data;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".sel"},   8'(bus.digit_sel),  8'd0);
    chk({tag, ".val"},   8'(bus.digit_val),  8'd0);
    chk({tag, ".on"},    8'(bus.digit_on),   8'd0);
    chk({tag, ".tick"},  8'(bus.scan_tick),  8'd0);
    chk({tag, ".frame"}, 8'(bus.frame_done), 8'd0);
  endtask

  task automatic check_all(input string tag);
    logic [1:0] s;
    logic       on_exp;
    logic       tick_exp;
    logic       frame_exp;
    s         = 2'((e / 4) % 4);
    tick_exp  = !bus.hold && (e % 4 == 0);
    frame_exp = !bus.hold && (e % 16 == 0);
`ifdef LEAD_ZERO_BLANK_EN
    on_exp = (s == 2'd0);
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(s) && mb[i] != 4'd0) on_exp = 1'b1;
    end
`else
    on_exp = 1'b1;
`endif
    chk({tag, ".sel"},   8'(bus.digit_sel),  8'(s));
    chk({tag, ".val"},   8'(bus.digit_val),  8'(mb[s]));
    chk({tag, ".on"},    8'(bus.digit_on),   8'(on_exp));
    chk({tag, ".tick"},  8'(bus.scan_tick),  8'(tick_exp));
    chk({tag, ".frame"}, 8'(bus.frame_done), 8'(frame_exp));
  endtask

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    total       = 0;
    bad         = 0;
    e           = 0;
    bus.hold    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_data = 4'd0;
    for (int i = 0; i < 4; i++) mb[i] = 4'd0;

    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan through one full frame plus the wrap.
    for (int k = 0; k < 17; k++) begin
      step();
      check_all("scan");
    end

    // Fill buffer 1,2,3,4 then watch a full frame.
    wr(3'd0, 4'd1); check_all("wr0");
    wr(3'd1, 4'd2); check_all("wr1");
    wr(3'd2, 4'd3); check_all("wr2");
    wr(3'd3, 4'd4); check_all("wr3");
    while (e < 48) begin
      step();
      check_all("readback");
    end

    // Write to the displayed digit: new value visible one cycle later.
    wr(3'd0, 4'd9);
    check_all("byp_cur");
    chk("byp_cur_val", 8'(bus.digit_val), 8'd9);

    // Write to index 2 on the 1->2 advance edge.
    while (e < 55) begin
      step();
      check_all("pre_adv");
    end
    wr(3'd2, 4'd5);
    check_all("byp_adv");
    chk("byp_adv_sel", 8'(bus.digit_sel), 8'd2);
    chk("byp_adv_val", 8'(bus.digit_val), 8'd5);

    // Out-of-range write must be invisible.
    wr(3'd6, 4'hf);
    check_all("oor_wr");
    chk("oor_val", 8'(bus.digit_val), 8'd5);

    // Hold mid-slot for 10 cycles; the slot then finishes its count.
    step();
    check_all("pre_hold");
    bus.hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_all("hold");
    end
    bus.hold = 1'b0;
    step();
    check_all("post_hold");
    chk("post_hold_sel", 8'(bus.digit_sel), 8'd2);
    step();
    check_all("post_hold_adv");
    chk("post_hold_tick", 8'(bus.scan_tick), 8'd1);
    chk("post_hold_sel3", 8'(bus.digit_sel), 8'd3);
    for (int k = 0; k < 16; k++) begin
      step();
      check_all("after_hold");
    end

    // Reach digit 2, then reset asynchronously between edges.
    while (e % 16 != 9) begin
      step();
      check_all("to_sel2");
    end
    chk("arst_pre_sel", 8'(bus.digit_sel), 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    e = 0;
    for (int i = 0; i < 4; i++) mb[i] = 4'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      check_all("cleared");
    end

    // Buffer {3:0, 2:0, 1:7, 0:0} exercises leading-zero blanking.
    wr(3'd1, 4'd7);
    check_all("lz_wr");
    while (e < 48) begin
      step();
      check_all("lzb");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
